// File: rtl/instr_reg_decode_if.sv
// Fetch/decode bundle for instr_reg_decode: control and memory inputs, latched
// instruction, decoded fields and status flags.
interface instr_reg_decode_if;
    logic        fetch_req;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_req;
    logic        ir_valid;
    logic [31:0] Instr31_0;
    logic [2:0]  InstrType;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic        illegal;
    logic        timeout;
    logic [31:0] instr_count;

    modport master (
        output fetch_req, mem_rdata, mem_valid,
        input  mem_req, ir_valid, Instr31_0, InstrType, opcode, rd, funct3, rs1, rs2,
               funct7, illegal, timeout, instr_count
    );

    modport slave (
        input  fetch_req, mem_rdata, mem_valid,
        output mem_req, ir_valid, Instr31_0, InstrType, opcode, rd, funct3, rs1, rs2,
               funct7, illegal, timeout, instr_count
    );
endinterface

// File: rtl/instr_reg_decode.sv
// Instruction register and primary decoder with fetch timeout and latch counter.
// Optional IR_ILLEGAL_TRAP_EN: unmapped opcodes decode as InstrType 111 and set illegal.
module instr_reg_decode #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic               clock,
    input logic               reset,
    instr_reg_decode_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StWait, StFull} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [2:0]  type_q, type_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    logic [31:0] count_q, count_d;

    logic [2:0]  dec_type;
    logic        dec_illegal;

    // Decode straight from the memory word so the result lands with the latch.
    always_comb begin
        dec_type    = 3'b000;
        dec_illegal = 1'b0;
        unique case (bus.mem_rdata[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: dec_type = 3'b000;
            7'b0100011:                                                 dec_type = 3'b001;
            7'b1100011:                                                 dec_type = 3'b010;
            7'b1101111:                                                 dec_type = 3'b011;
            7'b0110111, 7'b0010111:                                     dec_type = 3'b100;
            7'b0110011, 7'b0111011:                                     dec_type = 3'b101;
            default: begin
`ifdef IR_ILLEGAL_TRAP_EN
                dec_type    = 3'b111;
                dec_illegal = 1'b1;
`else
                dec_type    = 3'b000;
                dec_illegal = 1'b0;
`endif
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        instr_d    = instr_q;
        type_d     = type_q;
        illegal_d  = illegal_q;
        timeout_d  = 1'b0;
        count_d    = count_q;
        unique case (state_q)
            StIdle, StFull: begin
                if (bus.fetch_req) begin
                    state_d    = StWait;
                    wait_cnt_d = 8'd0;
                end
            end
            StWait: begin
                // A valid word on the expiry cycle still wins over the timeout.
                if (bus.mem_valid) begin
                    state_d   = StFull;
                    instr_d   = bus.mem_rdata;
                    type_d    = dec_type;
                    illegal_d = dec_illegal;
                    count_d   = count_q + 32'd1;
                end else if (wait_cnt_q == TimeoutLast) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= 8'd0;
            instr_q    <= 32'd0;
            type_q     <= 3'b000;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            instr_q    <= instr_d;
            type_q     <= type_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
            count_q    <= count_d;
        end
    end

    assign bus.mem_req     = (state_q == StWait);
    assign bus.ir_valid    = (state_q == StFull);
    assign bus.Instr31_0   = instr_q;
    assign bus.InstrType   = type_q;
    assign bus.opcode      = instr_q[6:0];
    assign bus.rd          = instr_q[11:7];
    assign bus.funct3      = instr_q[14:12];
    assign bus.rs1         = instr_q[19:15];
    assign bus.rs2         = instr_q[24:20];
    assign bus.funct7      = instr_q[31:25];
    assign bus.illegal     = illegal_q;
    assign bus.timeout     = timeout_q;
    assign bus.instr_count = count_q;

endmodule

// File: doc/instr_reg_decode.md
# instr_reg_decode

Instruction register and primary decoder for the multicycle RISC-V core. On request from the control unit it fetches one 32-bit instruction word from instruction memory, holds it stable, and decodes it into register indices, function fields and the 3-bit `InstrType` code consumed by the immediate sign-extension stage. It also detects illegal opcodes, flags memory timeouts, and counts the instructions it has latched.

## Interface
- `TIMEOUT`, default 16: number of WAIT cycles without `mem_valid` before the fetch is abandoned; legal range 2..255.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `fetch_req` in 1: control unit asks for the next instruction; sampled only in IDLE/FULL.
- `mem_rdata` in 32: instruction word from memory.
- `mem_valid` in 1: `mem_rdata` is valid this cycle.
- `mem_req` out 1: fetch outstanding (high exactly while in WAIT).
- `ir_valid` out 1: `Instr31_0` and the decoded fields hold a complete instruction.
- `Instr31_0` out 32: latched instruction word.
- `InstrType` out 3: 000 I, 001 S, 010 SB, 011 UJ, 100 U, 101 R (no immediate), 111 illegal.
- `opcode` out 7, `rd` out 5, `funct3` out 3, `rs1` out 5, `rs2` out 5, `funct7` out 7: `Instr31_0` slices [6:0], [11:7], [14:12], [19:15], [24:20], [31:25].
- `illegal` out 1: latched opcode is unsupported.
- `timeout` out 1: one-cycle pulse when a fetch is abandoned.
- `instr_count` out 32: number of instructions latched since reset.

## Operation
- FSM states: IDLE, WAIT, FULL. Reset state is IDLE.
- IDLE or FULL, `fetch_req`=1: go to WAIT, clear the wait counter, and drop `ir_valid`. `Instr31_0` keeps its old value.
- WAIT, `mem_valid`=1: latch `mem_rdata` into `Instr31_0`, register the decode outputs, increment `instr_count`, and go to FULL.
- WAIT, no `mem_valid`: increment the wait counter. When the counter reaches `TIMEOUT`-1 on a non-valid cycle, pulse `timeout` and go to IDLE.
- WAIT: `fetch_req` is ignored.
- IDLE and FULL: `mem_valid` is ignored.
- Same cycle `mem_valid` and timeout expiry: `mem_valid` wins; no `timeout` pulse.
- Opcode to `InstrType` mapping:
  - 0000011, 0010011, 0011011, 1100111, 1110011 → 000
  - 0100011 → 001
  - 1100011 → 010
  - 1101111 → 011
  - 0110111, 0010111 → 100
  - 0110011, 0111011 → 101
  - anything else → 111 with `illegal`=1 (see Configuration).
- `instr_count` wraps from 0xFFFFFFFF to 0.
- Decode outputs are registered. They are always consistent with `Instr31_0`.

## Timing
- Reset values:
  - `mem_req`, `ir_valid`, `illegal`, `timeout` = 0
  - `Instr31_0` = 0, with all slices therefore 0
  - `InstrType` = 000
  - `instr_count` = 0
- `fetch_req` at edge N: `mem_req`=1 from cycle N+1.
- `mem_valid` sampled at edge M: from cycle M+1, `ir_valid`=1, `mem_req`=0, and all decoded outputs are valid. Minimum request-to-valid latency is 2 cycles.
- `timeout`: asserted the cycle after the expiry edge, for exactly one cycle. `mem_req` falls in that same cycle.
- In FULL, the outputs are held indefinitely until the next `fetch_req` is accepted.
- `fetch_req` in FULL: `ir_valid` falls the next cycle. The previous `Instr31_0` stays visible, but consumers must qualify it with `ir_valid`.
- Reset mid-WAIT: go to IDLE next cycle with all reset values. A `mem_valid` arriving after reset is ignored.

## Configuration
- `IR_ILLEGAL_TRAP_EN` defined:
  - Unmapped opcodes produce `InstrType`=111 and `illegal`=1.
  - `illegal` holds until the next successful latch.
- `IR_ILLEGAL_TRAP_EN` undefined:
  - `illegal` is tied to 0.
  - Unmapped opcodes decode as `InstrType`=000 (I).
  - Code 111 is never produced.

## Test plan
- Reset, then `fetch_req`; `mem_valid` with 0x00500093 (addi x1,x0,5) three cycles later → `ir_valid`=1, `InstrType`=000, `rd`=1, `rs1`=0, `funct3`=0, `instr_count`=1.
- Fetch sequence 0xFE20AE23 (sw), 0xFE000EE3 (beq), 0x0080006F (jal), 0x123452B7 (lui), 0x002081B3 (add) → `InstrType` = 001, 010, 011, 100, 101 in turn; `instr_count`=5.
- `fetch_req` with `mem_valid` held low for `TIMEOUT`=16 cycles → `timeout` pulses once, state returns to IDLE, `instr_count` unchanged, `ir_valid`=0. In the same run, `mem_valid` arriving on the expiry cycle → latched, and no `timeout` pulse.
- Fetch 0xFFFFFFFF → with `IR_ILLEGAL_TRAP_EN`, `InstrType`=111 and `illegal`=1; without it, `InstrType`=000 and `illegal`=0. A following legal fetch clears `illegal`.
- Assert `reset` during WAIT, then drive `mem_valid` with 0x00500093 the following cycle → all outputs at reset values; instruction not latched; `instr_count`=0.
- Preload `instr_count` to 0xFFFFFFFF via forced state, then one fetch → `instr_count`=0. `fetch_req` pulsed during WAIT → ignored, exactly one latch.
